// File: rtl/char_feeder_if.sv
// Producer-side byte handshake plus the per-cycle character stream towards id_fsm.
// The slave modport is the char_feeder view; master is the producer/consumer view.
interface char_feeder_if #(
    parameter int unsigned DEPTH = 8
);
    logic [7:0]              in_char;
    logic                    in_valid;
    logic                    in_ready;
    logic                    hold;
    logic [7:0]              char;
    logic                    char_valid;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;

    modport master (
        output in_char, in_valid, hold,
        input  in_ready, char, char_valid, count, overflow
    );

    modport slave (
        input  in_char, in_valid, hold,
        output in_ready, char, char_valid, count, overflow
    );
endinterface

// File: rtl/char_feeder.sv
// Small FIFO that turns a valid/ready byte stream into one registered character per
// clock for id_fsm, substituting FILL whenever nothing is buffered.
module char_feeder #(
    parameter int unsigned DEPTH = 8,
    parameter logic [7:0]  FILL  = 8'h20
) (
    input logic          clk,
    input logic          reset,
    char_feeder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_r;
    logic [7:0]    char_r;
    logic          char_valid_r;
    logic          overflow_r;
    logic          push;
    logic          pop;

    // Ready depends only on the registered count, so a pop never frees a slot
    // in the same cycle.
    assign bus.in_ready   = (count_r != FULL);
    assign bus.char       = char_r;
    assign bus.char_valid = char_valid_r;
    assign bus.count      = count_r;
    assign bus.overflow   = overflow_r;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = !bus.hold && (count_r != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_char;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_r      <= '0;
            char_r       <= FILL;
            char_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            if (pop) begin
                char_r       <= mem[rd_ptr];
                char_valid_r <= 1'b1;
                rd_ptr       <= rd_ptr + AW'(1);
            end else if (!bus.hold) begin
                char_r       <= FILL;
                char_valid_r <= 1'b0;
            end

            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase

            if (bus.in_valid && !bus.in_ready) begin
                overflow_r <= 1'b1;
            end
        end
    end
endmodule
